// File: rtl/lut_pkg.sv
// Shared types and sizes for the mem_LUT arbiter.
// 32-entry x 8-bit lookup table, two requesters.
package lut_pkg;
    localparam int LUT_ADDR_W  = 5;
    localparam int LUT_DATA_W  = 8;
    localparam int LUT_ENTRIES = 32;

    typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
    typedef logic [LUT_DATA_W-1:0] lut_data_t;
    typedef logic                  req_id_t;
endpackage

// File: rtl/lut_arbiter_if.sv
// Request/response handshakes of both requesters plus the mem_LUT port.
// master = requesters and mem_LUT side, slave = the arbiter.
interface lut_arbiter_if;
    import lut_pkg::*;

    logic      req0_valid;
    lut_addr_t req0_addr;
    logic      req0_ready;
    logic      rsp0_valid;
    lut_data_t rsp0_data;
    logic      rsp0_ready;

    logic      req1_valid;
    lut_addr_t req1_addr;
    logic      req1_ready;
    logic      rsp1_valid;
    lut_data_t rsp1_data;
    logic      rsp1_ready;

    lut_addr_t lut_addr;
    lut_data_t lut_data;

    modport master (
        output req0_valid, req0_addr, rsp0_ready,
        output req1_valid, req1_addr, rsp1_ready,
        output lut_data,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  lut_addr
    );

    modport slave (
        input  req0_valid, req0_addr, rsp0_ready,
        input  req1_valid, req1_addr, rsp1_ready,
        input  lut_data,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output lut_addr
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that
// did not win last time is granted. Grant is one-hot or zero.
module rr_arb2
    import lut_pkg::*;
(
    input  logic [1:0] eligible,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/lut_arbiter.sv
// Shares one combinational mem_LUT between two requesters through a
// registered lookup stage and per-requester response registers.
module lut_arbiter
    import lut_pkg::*;
#(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    lut_arbiter_if.slave  bus
);

    logic                   l_valid;
    req_id_t                l_id;
    logic [ADDR_W-1:0]      l_addr;
    req_id_t                last_grant;

    logic [1:0]             req_valid;
    logic [1:0]             rsp_ready;
    logic [1:0]             rsp_valid;
    logic [1:0][DATA_W-1:0] rsp_data;
    logic [1:0]             busy;
    logic [1:0]             eligible;
    logic [1:0]             grant;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    // A requester stays busy from accept until its response is consumed.
    assign busy[0] = (l_valid && l_id == 1'b0) || rsp_valid[0];
    assign busy[1] = (l_valid && l_id == 1'b1) || rsp_valid[1];
    assign eligible = req_valid & ~busy & {2{~reset}};

    rr_arb2 u_arb (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.lut_addr   = l_addr;
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp0_data  = rsp_data[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp1_data  = rsp_data[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_valid    <= 1'b0;
            l_id       <= 1'b0;
            l_addr     <= '0;
            last_grant <= 1'b1;
        end else if (|grant) begin
            l_valid    <= 1'b1;
            l_id       <= grant[1];
            l_addr     <= grant[1] ? bus.req1_addr : bus.req0_addr;
            last_grant <= grant[1];
        end else begin
            l_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (l_valid && l_id == req_id_t'(x)) begin
                    rsp_valid[x] <= 1'b1;
                    rsp_data[x]  <= bus.lut_data;
                end else if (rsp_valid[x] && rsp_ready[x]) begin
                    rsp_valid[x] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// Bench for lut_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of the two requesters.
module tb_lut_arbiter;
    import lut_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    lut_arbiter_if bus ();

    lut_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for mem_LUT: entries 0-13 hold 60+addr, the rest arbitrary.
    function automatic lut_data_t lut(input lut_addr_t a);
        lut_data_t t;
        t = {3'b000, a};
        return (a < 5'd14) ? t + 8'd60 : (t * 8'd7) ^ 8'h5A;
    endfunction

    assign bus.lut_data = lut(bus.lut_addr);

    // Model: each requester has at most one outstanding lookup,
    // visible as a response two cycles after its accept cycle.
    int        cyc;
    logic      last_m;
    lut_addr_t laddr_m;
    logic      outst [2];
    int        acc   [2];
    lut_data_t pend  [2];
    lut_data_t data_m[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_m  = 1'b1;
        laddr_m = '0;
        for (int x = 0; x < 2; x++) begin
            outst[x]  = 1'b0;
            acc[x]    = 0;
            pend[x]   = '0;
            data_m[x] = '0;
        end
    endtask

    task automatic step(input logic v0, input lut_addr_t a0, input logic r0,
                        input logic v1, input lut_addr_t a1, input logic r1,
                        input logic rs);
        logic [1:0] ev, el, g, rr;
        lut_addr_t  aa [2];
        @(negedge clk);
        reset          = rs;
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.rsp0_ready = r0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.rsp1_ready = r1;
        if (rs) model_reset();
        #1;
        aa[0] = a0;
        aa[1] = a1;
        rr    = {r1, r0};
        for (int x = 0; x < 2; x++)
            ev[x] = outst[x] && (cyc >= acc[x] + 2);
        el = {v1 && !outst[1], v0 && !outst[0]};
        if (rs)               g = 2'b00;
        else if (el == 2'b11) g = last_m ? 2'b01 : 2'b10;
        else                  g = el;
        chk("req0_ready", bus.req0_ready, g[0]);
        chk("req1_ready", bus.req1_ready, g[1]);
        chk("lut_addr",   bus.lut_addr,   laddr_m);
        chk("rsp0_valid", bus.rsp0_valid, ev[0]);
        chk("rsp1_valid", bus.rsp1_valid, ev[1]);
        chk("rsp0_data",  bus.rsp0_data,  data_m[0]);
        chk("rsp1_data",  bus.rsp1_data,  data_m[1]);
        if (!rs) begin
            for (int x = 0; x < 2; x++)
                if (ev[x] && rr[x]) outst[x] = 1'b0;
            for (int x = 0; x < 2; x++)
                if (g[x]) begin
                    outst[x] = 1'b1;
                    acc[x]   = cyc;
                    pend[x]  = lut(aa[x]);
                    laddr_m  = aa[x];
                    last_m   = x[0];
                end
        end
        cyc++;
        for (int x = 0; x < 2; x++)
            if (outst[x] && cyc == acc[x] + 2) data_m[x] = pend[x];
    endtask

    task automatic idle(input logic r0, input logic r1);
        step(1'b0, '0, r0, 1'b0, '0, r1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        model_reset();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.rsp1_ready = 1'b1;
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 1, 0, 0, 1, 1);
        idle(1, 1);

        // single lookup, addr 5
        step(1, 5, 1, 0, 0, 1, 0);
        chk("d1_ready0", bus.req0_ready, 1);
        idle(1, 1);
        chk("d1_lut_addr", bus.lut_addr, 5);
        idle(1, 1);
        chk("d1_valid", bus.rsp0_valid, 1);
        chk("d1_data", bus.rsp0_data, 65);
        idle(1, 1);
        chk("d1_valid_clr", bus.rsp0_valid, 0);

        // first tie after reset goes to req0
        step(0, 0, 1, 0, 0, 1, 1);
        step(1, 0, 1, 1, 13, 1, 0);
        chk("d2_ready0", bus.req0_ready, 1);
        chk("d2_ready1", bus.req1_ready, 0);
        step(0, 0, 1, 1, 13, 1, 0);
        chk("d2_ready1b", bus.req1_ready, 1);
        idle(1, 1);
        chk("d2_data0", bus.rsp0_data, 60);
        idle(1, 1);
        chk("d2_data1", bus.rsp1_data, 73);
        idle(1, 1);

        // make req0 the last winner, then tie goes to req1
        step(1, 1, 1, 0, 0, 1, 0);
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);
        step(1, 3, 1, 1, 7, 1, 0);
        chk("d3_ready1", bus.req1_ready, 1);
        step(1, 3, 1, 0, 0, 1, 0);
        chk("d3_ready0", bus.req0_ready, 1);
        idle(1, 1);
        chk("d3_data1", bus.rsp1_data, 67);
        idle(1, 1);
        chk("d3_data0", bus.rsp0_data, 63);
        idle(1, 1);

        // rsp1 backpressure stalls only requester 1
        step(0, 0, 1, 1, 10, 0, 0);
        idle(1, 0);
        idle(1, 0);
        chk("d4_data70", bus.rsp1_data, 70);
        step(1, 2, 1, 1, 11, 0, 0);
        chk("d4_ready0", bus.req0_ready, 1);
        chk("d4_blocked", bus.req1_ready, 0);
        step(0, 0, 1, 1, 11, 0, 0);
        step(0, 0, 1, 1, 11, 0, 0);
        chk("d4_data62", bus.rsp0_data, 62);
        chk("d4_blocked2", bus.req1_ready, 0);
        step(0, 0, 1, 1, 11, 1, 0);
        chk("d4_hs_block", bus.req1_ready, 0);
        step(0, 0, 1, 1, 11, 1, 0);
        chk("d4_accept", bus.req1_ready, 1);
        idle(1, 1);
        idle(1, 1);
        chk("d4_data71", bus.rsp1_data, 71);
        idle(1, 1);

        // reset mid-flight drops the lookup
        step(1, 9, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 1);
        chk("d5_lut_addr", bus.lut_addr, 0);
        step(0, 0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            idle(1, 1);
            chk("d5_no_rsp", bus.rsp0_valid, 0);
        end
        step(1, 9, 1, 0, 0, 1, 0);
        idle(1, 1);
        idle(1, 1);
        chk("d5_data69", bus.rsp0_data, 69);
        idle(1, 1);

        // top address
        step(1, 31, 1, 0, 0, 1, 0);
        idle(1, 1);
        chk("d6_lut_addr", bus.lut_addr, 31);
        idle(1, 1);
        chk("d6_data", bus.rsp0_data, lut(5'd31));
        idle(1, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), lut_addr_t'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), lut_addr_t'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 255) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
